hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clock.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 idRs1, idRs2  in  5 each  source register indices of the instruction in decode.
REQ-005 idUsesRs1, idUsesRs2  in  1 each  decode instruction reads that source.
REQ-006 exMemRead  in  1  instruction in execute is a load.
REQ-007 exRd  in  5  destination register index of the instruction in execute.
REQ-008 branchTaken  in  1  execute resolved a taken branch or jump this cycle.
REQ-009 imemReady  in  1  instruction at the current PC is valid this cycle.
REQ-010 pcWrite  out  1  PC register load enable.
REQ-011 pcSelTarget  out  1  PC loads the branch target instead of PC+4.
REQ-012 ifIdWrite  out  1  fetch-to-decode register load enable.
REQ-013 ifIdFlush  out  1  fetch-to-decode register loads a NOP (0x00000013) with PC 0.
REQ-014 idExFlush  out  1  decode-to-execute register loads a bubble.
REQ-015 stallCycles  out  16  saturating count of cycles with pcWrite=0.
REQ-016 redirectCount  out  16  saturating count of accepted redirects.

Function
REQ-017 loadUse SHALL be exMemRead and exRd!=0 and ((idUsesRs1 and idRs1==exRd) or (idUsesRs2 and idRs2==exRd)).
REQ-018 FSM states SHALL be RUN, IMEM_WAIT and REDIRECT_WAIT; outputs are combinational from state and inputs.
REQ-019 Priority in every state SHALL be: branchTaken, then loadUse, then fetch status.
REQ-020 branchTaken in RUN or IMEM_WAIT: pcWrite=1, pcSelTarget=1, ifIdWrite=1, ifIdFlush=1, idExFlush=1; loadUse ignored; redirectCount increments.
REQ-021 After such a redirect, next state SHALL be RUN if imemReady=1, else REDIRECT_WAIT.
REQ-022 loadUse without branchTaken: pcWrite=0, ifIdWrite=0, ifIdFlush=0, idExFlush=1; the fetch is replayed and the next state SHALL be RUN.
REQ-023 RUN, no branch, no loadUse: imemReady=1 gives pcWrite=1, ifIdWrite=1, flushes 0, stay RUN; imemReady=0 gives pcWrite=0, ifIdWrite=1, ifIdFlush=1, next IMEM_WAIT.
REQ-024 IMEM_WAIT, no branch, no loadUse: same outputs as RUN for the given imemReady; imemReady=1 SHALL return to RUN.
REQ-025 REDIRECT_WAIT: pcWrite=0, ifIdWrite=1, ifIdFlush=1, idExFlush=branchTaken; imemReady=1 discards the stale fetch and SHALL go to RUN.
REQ-026 branchTaken in REDIRECT_WAIT SHALL additionally set pcWrite=1, pcSelTarget=1, increment redirectCount, and remain in REDIRECT_WAIT unless imemReady=1.
REQ-027 pcSelTarget SHALL be 0 whenever branchTaken=0.
REQ-028 Counters SHALL saturate at 0xFFFF and never wrap.

Reset
REQ-029 While reset=1: state RUN, stallCycles=0, redirectCount=0, pcWrite=0, ifIdWrite=1, ifIdFlush=1, idExFlush=1, pcSelTarget=0.
REQ-030 Reset asserted mid-wait SHALL abandon the outstanding fetch; the first cycle after reset SHALL behave as RUN.

Verification
REQ-031 exMemRead=1, exRd=5, idRs2=5, idUsesRs2=1, imemReady=1 -> one cycle pcWrite=0, ifIdWrite=0, idExFlush=1; stallCycles 0->1; next cycle normal.
REQ-032 exRd=0 with matching idRs1=0 and exMemRead=1 -> no stall.
REQ-033 branchTaken=1 with simultaneous loadUse and imemReady=1 -> flush both registers, pcSelTarget=1, redirectCount=1, no stall.
REQ-034 imemReady low 3 cycles from RUN -> 3 cycles pcWrite=0 with ifIdFlush=1, state IMEM_WAIT, stallCycles=3, RUN on ready.
REQ-035 branchTaken with imemReady=0, ready after 2 cycles -> REDIRECT_WAIT, stale fetch flushed on ready, then RUN.
REQ-036 Force stallCycles to 0xFFFE, stall 3 cycles -> holds 0xFFFF; reset mid-REDIRECT_WAIT -> RUN with counters 0.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if
//   Groups the pipeline-hazard signals exchanged between the datapath and the
//   hazard control unit.
//   Datapath -> unit : idRs1, idRs2, idUsesRs1, idUsesRs2, exMemRead, exRd,
//                      branchTaken, imemReady
//   Unit -> datapath : pcWrite, pcSelTarget, ifIdWrite, ifIdFlush, idExFlush,
//                      stallCycles, redirectCount
//   modport slave  : the hazard control unit itself
//   modport master : the datapath (or a testbench standing in for it)
interface hazard_control_unit_if;
  logic [4:0]  idRs1;
  logic [4:0]  idRs2;
  logic        idUsesRs1;
  logic        idUsesRs2;
  logic        exMemRead;
  logic [4:0]  exRd;
  logic        branchTaken;
  logic        imemReady;
  logic        pcWrite;
  logic        pcSelTarget;
  logic        ifIdWrite;
  logic        ifIdFlush;
  logic        idExFlush;
  logic [15:0] stallCycles;
  logic [15:0] redirectCount;

  modport slave (
    input  idRs1, idRs2, idUsesRs1, idUsesRs2, exMemRead, exRd,
           branchTaken, imemReady,
    output pcWrite, pcSelTarget, ifIdWrite, ifIdFlush, idExFlush,
           stallCycles, redirectCount
  );

  modport master (
    output idRs1, idRs2, idUsesRs1, idUsesRs2, exMemRead, exRd,
           branchTaken, imemReady,
    input  pcWrite, pcSelTarget, ifIdWrite, ifIdFlush, idExFlush,
           stallCycles, redirectCount
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller for a 5-stage in-order core. Detects load-use
//   hazards, applies branch/jump redirects, and holds the front end while the
//   instruction memory is not ready. A redirect issued while a fetch is still
//   outstanding waits for that stale fetch and discards it.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-high reset
//     bus   : hazard_control_unit_if.slave (hazard inputs, pipeline controls,
//             stall/redirect statistics counters)
//   The pipeline controls are combinational from the state and the inputs;
//   the state and the two saturating counters are registered.
module hazard_control_unit (
  input  logic                   clock,
  input  logic                   reset,
  hazard_control_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    IMEM_WAIT     = 2'd1,
    REDIRECT_WAIT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] stall_cycles_r;
  logic [15:0] redirect_count_r;

  logic load_use_s;
  logic pc_write_s;
  logic pc_sel_target_s;
  logic if_id_write_s;
  logic if_id_flush_s;
  logic id_ex_flush_s;

  // Load-use hazard: decode reads the register a load in execute will write.
  always_comb begin
    load_use_s = 1'b0;
    if (bus.exMemRead && (bus.exRd != 5'd0) &&
        ((bus.idUsesRs1 && (bus.idRs1 == bus.exRd)) ||
         (bus.idUsesRs2 && (bus.idRs2 == bus.exRd)))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Pipeline control decode and next-state selection.
  always_comb begin
    // Reset-state controls: hold PC, fill both pipeline registers with bubbles.
    pc_write_s      = 1'b0;
    pc_sel_target_s = 1'b0;
    if_id_write_s   = 1'b1;
    if_id_flush_s   = 1'b1;
    id_ex_flush_s   = 1'b1;
    next_state_s    = RUN;

    if (reset) begin
      next_state_s = RUN;
    end else begin
      case (state_r)
        RUN, IMEM_WAIT: begin
          if (bus.branchTaken) begin
            pc_write_s      = 1'b1;
            pc_sel_target_s = 1'b1;
            if_id_write_s   = 1'b1;
            if_id_flush_s   = 1'b1;
            id_ex_flush_s   = 1'b1;
            // Without a ready fetch the in-flight one is for the wrong path.
            next_state_s    = bus.imemReady ? RUN : REDIRECT_WAIT;
          end else if (load_use_s) begin
            // Freeze PC and IF/ID, bubble into execute; fetch is replayed.
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            if_id_flush_s = 1'b0;
            id_ex_flush_s = 1'b1;
            next_state_s  = RUN;
          end else if (bus.imemReady) begin
            pc_write_s    = 1'b1;
            if_id_write_s = 1'b1;
            if_id_flush_s = 1'b0;
            id_ex_flush_s = 1'b0;
            next_state_s  = RUN;
          end else begin
            // Fetch not ready: hold PC, feed a NOP into decode.
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b1;
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b0;
            next_state_s  = IMEM_WAIT;
          end
        end
        REDIRECT_WAIT: begin
          // Decode holds a flushed NOP here, so load-use cannot apply; any
          // arriving fetch is stale and is discarded.
          pc_write_s      = bus.branchTaken;
          pc_sel_target_s = bus.branchTaken;
          if_id_write_s   = 1'b1;
          if_id_flush_s   = 1'b1;
          id_ex_flush_s   = bus.branchTaken;
          next_state_s    = bus.imemReady ? RUN : REDIRECT_WAIT;
        end
        default: begin
          next_state_s = RUN;
        end
      endcase
    end
  end

  // State register and saturating statistics counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= RUN;
      stall_cycles_r   <= 16'd0;
      redirect_count_r <= 16'd0;
    end else begin
      state_r <= next_state_s;
      if (!pc_write_s && (stall_cycles_r != 16'hFFFF)) begin
        stall_cycles_r <= stall_cycles_r + 16'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (bus.branchTaken && (redirect_count_r != 16'hFFFF)) begin
        redirect_count_r <= redirect_count_r + 16'd1;
      end else begin
        redirect_count_r <= redirect_count_r;
      end
    end
  end

  assign bus.pcWrite       = pc_write_s;
  assign bus.pcSelTarget   = pc_sel_target_s;
  assign bus.ifIdWrite     = if_id_write_s;
  assign bus.ifIdFlush     = if_id_flush_s;
  assign bus.idExFlush     = id_ex_flush_s;
  assign bus.stallCycles   = stall_cycles_r;
  assign bus.redirectCount = redirect_count_r;

endmodule
